// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
//   NUM_WB_SRC        : number of result producers sharing the write port
//   WB_SRC_*          : source indices, also the wb_src / mux select encoding
//   wb_next_ptr()     : round-robin pointer advance after a grant
package wb_arb_pkg;

    localparam int NUM_WB_SRC = 5;

    localparam logic [2:0] WB_SRC_ALU    = 3'd0;
    localparam logic [2:0] WB_SRC_LOAD   = 3'd1;
    localparam logic [2:0] WB_SRC_MULDIV = 3'd2;
    localparam logic [2:0] WB_SRC_CSR    = 3'd3;
    localparam logic [2:0] WB_SRC_LINK   = 3'd4;

    // The pointer moves to the slot just after the winner, wrapping 4 -> 0.
    function automatic logic [2:0] wb_next_ptr(input logic [2:0] gsel);
        return (gsel == WB_SRC_LINK) ? WB_SRC_ALU : gsel + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotate-priority picker over five requesters.
//   valid  : request vector, bit i = source i
//   ptr    : highest-priority source this cycle (0..4)
//   en     : when low no grant is issued
//   onehot : one-hot grant (or zero)
//   idx    : encoded grant index, 0 when no grant
//   any    : a grant is issued
module rr_pick5
    import wb_arb_pkg::*;
(
    input  logic [4:0] valid,
    input  logic [2:0] ptr,
    input  logic       en,
    output logic [4:0] onehot,
    output logic [2:0] idx,
    output logic       any
);

    logic [2:0] w_start;
    int         w_cand;

    // ptr is never above 4; clamp anyway so the scan stays in range.
    assign w_start = (ptr > WB_SRC_LINK) ? WB_SRC_ALU : ptr;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        if (en) begin
            for (int k = 0; k < NUM_WB_SRC; k++) begin
                w_cand = int'(w_start) + k;
                if (w_cand >= NUM_WB_SRC) begin
                    w_cand = w_cand - NUM_WB_SRC;
                end
                if (!any && valid[w_cand]) begin
                    any            = 1'b1;
                    idx            = 3'(w_cand);
                    onehot[w_cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_mux5.sv
// 5:1 writeback select mux.
//   d : packed inputs, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s : select 0..4 (5..7 yield zero)
//   y : selected input
module wb_mux5
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [NUM_WB_SRC*DATA_WIDTH-1:0] d,
    input  logic [2:0]                       s,
    output logic [DATA_WIDTH-1:0]            y
);

    always_comb begin
        y = '0;
        case (s)
            WB_SRC_ALU:    y = d[0*DATA_WIDTH +: DATA_WIDTH];
            WB_SRC_LOAD:   y = d[1*DATA_WIDTH +: DATA_WIDTH];
            WB_SRC_MULDIV: y = d[2*DATA_WIDTH +: DATA_WIDTH];
            WB_SRC_CSR:    y = d[3*DATA_WIDTH +: DATA_WIDTH];
            WB_SRC_LINK:   y = d[4*DATA_WIDTH +: DATA_WIDTH];
            default:       y = '0;
        endcase
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single regfile write port, shared by
// ALU(0), load(1), mul/div(2), CSR(3) and PC+4 link(4).
//   req_valid/req_rd/req_data : per-source results, held until granted
//   req_ready                 : one-hot combinational grant
//   wb_valid/wb_ready         : one-entry output stage handshake; a transfer
//                               happens on a cycle where both are high
//   wb_we                     : write enable, suppressed for x0
//   wb_rd/wb_data/wb_src      : registered winner
//   busy_stall                : a request is pending but nothing is granted
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [4:0]                       req_valid,
    input  logic [NUM_WB_SRC*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_WB_SRC*DATA_WIDTH-1:0] req_data,
    output logic [4:0]                       req_ready,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic                             wb_we,
    output logic [REG_ADDR_W-1:0]            wb_rd,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic [2:0]                       wb_src,
    output logic                             busy_stall
);

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [2:0]            r_wb_src;
    logic [2:0]            r_rr_ptr;

    logic                  w_load_en;
    logic                  w_any;
    logic [2:0]            w_gsel;
    logic [4:0]            w_onehot;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [REG_ADDR_W-1:0] w_sel_rd;

    // Stage accepts a new entry when empty or being drained this cycle.
    // Grants are held off while rst is asserted.
    assign w_load_en = (!r_wb_valid || wb_ready) && !rst;

    rr_pick5 u_pick (
        .valid  (req_valid),
        .ptr    (r_rr_ptr),
        .en     (w_load_en),
        .onehot (w_onehot),
        .idx    (w_gsel),
        .any    (w_any)
    );

    wb_mux5 #(.DATA_WIDTH(DATA_WIDTH)) u_data_mux (
        .d (req_data),
        .s (w_gsel),
        .y (w_sel_data)
    );

    wb_mux5 #(.DATA_WIDTH(REG_ADDR_W)) u_rd_mux (
        .d (req_rd),
        .s (w_gsel),
        .y (w_sel_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_src   <= WB_SRC_ALU;
            r_rr_ptr   <= WB_SRC_ALU;
        end else if (w_any) begin
            // A grant overwrites the stage even if it is draining this cycle.
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_sel_rd;
            r_wb_data  <= w_sel_data;
            r_wb_src   <= w_gsel;
            r_rr_ptr   <= wb_next_ptr(w_gsel);
        end else if (r_wb_valid && wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign req_ready  = w_onehot;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign wb_src     = r_wb_src;
    assign wb_we      = r_wb_valid && (r_wb_rd != '0);
    assign busy_stall = (|req_valid) && !w_any;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NS = 5;
  localparam int EW = 3 + AW + DW;

  logic           clk;
  logic           rst;
  logic [4:0]     req_valid;
  logic [NS*AW-1:0] req_rd;
  logic [NS*DW-1:0] req_data;
  logic [4:0]     req_ready;
  logic           wb_valid;
  logic           wb_ready;
  logic           wb_we;
  logic [AW-1:0]  wb_rd;
  logic [DW-1:0]  wb_data;
  logic [2:0]     wb_src;
  logic           busy_stall;

  wb_port_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_src     (wb_src),
    .busy_stall (busy_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard: entry = {src, rd, data}
  logic [EW-1:0] exp_q[$];

  // requester state owned by the driver
  logic [4:0]    s_v;
  logic [AW-1:0] s_rd[NS];
  logic [DW-1:0] s_d[NS];
  logic [4:0]    last_grant;

  // reference model state
  int   m_ptr;
  logic m_valid;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic apply();
    req_valid = s_v;
    for (int i = 0; i < NS; i++) begin
      req_rd[i*AW +: AW] = s_rd[i];
      req_data[i*DW +: DW] = s_d[i];
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (last_grant[i]) s_v[i] = 1'b0;
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    if (!s_v[i]) begin
      s_v[i] = 1'b1;
      s_rd[i] = rd;
      s_d[i] = d;
    end
  endtask

  task automatic post_rand(input int i);
    post(i, AW'($urandom_range(0, 31)), {$urandom, $urandom});
  endtask

  task automatic drive(input logic rdy);
    wb_ready = rdy;
    apply();
  endtask

  // reference model: nearest valid source at or after the pointer, wrapping
  always @(negedge clk) begin
    int best;
    int bestd;
    int d;
    logic load_en;
    logic [4:0] exp_rr;
    #2;
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      chk("stall_in_reset", 64'(busy_stall), 64'(|req_valid));
      last_grant = '0;
    end else begin
      load_en = !m_valid || wb_ready;
      best = -1;
      bestd = NS;
      if (load_en) begin
        for (int i = 0; i < NS; i++) begin
          if (req_valid[i]) begin
            d = (i - m_ptr + NS) % NS;
            if (d < bestd) begin
              bestd = d;
              best = i;
            end
          end
        end
      end
      exp_rr = (best >= 0) ? 5'(1 << best) : 5'd0;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      chk("busy_stall", 64'(busy_stall), 64'((|req_valid) && best < 0));
      if (best >= 0) begin
        exp_q.push_back({3'(best), req_rd[best*AW +: AW], req_data[best*DW +: DW]});
        m_ptr = (best + 1) % NS;
        m_valid = 1'b1;
      end else if (wb_ready) begin
        m_valid = 1'b0;
      end
      last_grant = exp_rr;
    end
  end

  // monitor: compares the output stage against the scoreboard head
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (rst) begin
      chk("valid_in_reset", 64'(wb_valid), 64'd0);
    end else begin
      chk("wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0));
      if (wb_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("wb_src", 64'(wb_src), 64'(e[EW-1 -: 3]));
        chk("wb_rd", 64'(wb_rd), 64'(e[DW +: AW]));
        chk("wb_data", wb_data, e[DW-1:0]);
        chk("wb_we", 64'(wb_we), 64'(e[DW +: AW] != 0));
        if (wb_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      drive(1'b1);
    end
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      next_cycle();
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 2) == 0) post_rand(i);
      end
      drive($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_v = '0;
    last_grant = '0;
    m_ptr = 0;
    m_valid = 1'b0;
    wb_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_rd[i] = '0;
      s_d[i] = '0;
    end
    apply();
    repeat (2) @(negedge clk);
    #4;
    chk("reset_data", wb_data, 64'd0);
    chk("reset_src", 64'(wb_src), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single request from the load unit
    next_cycle();
    post(1, 5'd7, 64'h1234);
    drive(1'b1);
    idle(3);

    // all five valid continuously
    repeat (8) begin
      next_cycle();
      for (int i = 0; i < NS; i++) post_rand(i);
      drive(1'b1);
    end
    idle(6);

    // backpressure: stage full, consumer stalled, mul/div waiting
    next_cycle();
    post(0, 5'd9, 64'h55);
    drive(1'b1);
    repeat (3) begin
      next_cycle();
      post(2, 5'd11, 64'hBEEF);
      drive(1'b0);
    end
    next_cycle();
    drive(1'b1);
    idle(3);

    // CSR result to x0
    next_cycle();
    post(3, 5'd0, 64'hFFFF);
    drive(1'b1);
    idle(3);

    // wrap-around: grant 3 moves pointer to 4, then 4 and 0 compete
    next_cycle();
    post(3, 5'd1, 64'h33);
    drive(1'b1);
    next_cycle();
    post(4, 5'd2, 64'h44);
    post(0, 5'd3, 64'h0);
    drive(1'b1);
    idle(4);

    random_phase(300);
    idle(12);

    // asynchronous reset while the stage holds 0xAA
    next_cycle();
    post(0, 5'd3, 64'hAA);
    drive(1'b1);
    next_cycle();
    drive(1'b0);
    #3;
    rst = 1'b1;
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr = 0;
    last_grant = '0;
    #1;
    chk("async_rst_valid", 64'(wb_valid), 64'd0);
    chk("async_rst_data", wb_data, 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    post(1, 5'd4, 64'h77);
    drive(1'b1);
    @(negedge clk);
    // pointer must restart at 0: sources 0 and 1 both pending
    rst = 1'b0;
    post(0, 5'd5, 64'h66);
    drive(1'b1);

    random_phase(300);

    // drain everything, bounded
    repeat (40) begin
      next_cycle();
      drive(1'b1);
      if (s_v == '0 && exp_q.size() == 0) break;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_sources_done", 64'(s_v), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port of the RV64 core among five result producers: 0 ALU, 1 load unit, 2 mul/div, 3 CSR, 4 PC+4 link.
- Each cycle it picks at most one valid producer round-robin and drives the 5:1 writeback data-select mux with the grant.
- Registers the winner's data and destination into a one-entry output stage with a valid/ready handshake toward the regfile and forwarding logic.

Parameters:
- DATA_WIDTH, 64, width of each result and of wb_data
- REG_ADDR_W, 5, width of destination register index

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  5  per-source result valid, bit i = source i
- req_rd  input  5*REG_ADDR_W  packed destination indices, source i at [i*REG_ADDR_W +: REG_ADDR_W]
- req_data  input  5*DATA_WIDTH  packed results, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  5  one-hot grant, combinational; source i's transfer completes when req_valid[i] && req_ready[i]
- wb_valid  output  1  output stage holds a result
- wb_ready  input  1  consumer accepts the output stage this cycle
- wb_we  output  1  regfile write enable = wb_valid && (wb_rd != 0)
- wb_rd  output  REG_ADDR_W  registered destination
- wb_data  output  DATA_WIDTH  registered result
- wb_src  output  3  registered source index, mux encoding 3'b000..3'b100
- busy_stall  output  1  some req_valid is high but no grant is issued this cycle

Behaviour:
- Reset (asynchronous, active-high): wb_valid=0, wb_rd=0, wb_data=0, wb_src=3'b000, rr_ptr=0. req_ready is 0 while rst is high.
- load_en = !wb_valid || wb_ready. The output stage can take a new entry in the same cycle it is drained, giving full throughput.
- Grant:
  - If load_en=0, req_ready=0.
  - Otherwise, scan sources starting at rr_ptr and wrapping 4→0. Grant the first one with req_valid high. req_ready is one-hot or zero.
- Select: grant index gsel[2:0] drives the 5:1 data mux and the rd mux. Encoding 000..100. Values 101..111 are never produced.
- On a grant at clock edge:
  - wb_data ← mux(req_data, gsel); wb_rd ← req_rd[gsel]; wb_src ← gsel; wb_valid ← 1.
  - rr_ptr ← (gsel==4) ? 0 : gsel+1.
- No grant and wb_ready && wb_valid → wb_valid ← 0. Data and rd hold their last values.
- No grant and wb_valid && !wb_ready → all output registers hold.
- rr_ptr changes only on a grant.
- Latency: request to wb_valid is 1 cycle when not stalled.
- Requester rule: req_valid, req_rd and req_data must stay stable until granted. The arbiter does not sample a source before it is granted.
- rd=0 results are granted and consumed normally, but wb_we=0 (x0 is never written).
- Starvation bound: a continuously valid source is granted within 5 grants.
- busy_stall = |req_valid && !(|req_ready). It covers both backpressure and the reset window.
- Simultaneous drain and load: the new entry overwrites; wb_valid stays 1.

Decomposition:
- Package wb_arb_pkg:
  - NUM_WB_SRC=5
  - WB_SRC_ALU=3'd0, WB_SRC_LOAD=3'd1, WB_SRC_MULDIV=3'd2, WB_SRC_CSR=3'd3, WB_SRC_LINK=3'd4
- Sub-module rr_pick5: combinational rotate-priority picker.
  - Inputs: valid[4:0], ptr[2:0], en.
  - Outputs: onehot[4:0], idx[2:0], any.
- Data selection instantiates the existing 5:1 mux with s=idx. The rd select uses a second instance with DATA_WIDTH=REG_ADDR_W.

Test Plan:
- Reset mid-stream: wb_valid=1 holding data 0xAA, assert rst asynchronously → wb_valid=0, wb_data=0, rr_ptr=0 before the next edge; req_ready=0 while rst is high.
- Single request: req_valid=5'b00010, rd=7, data=0x1234, wb_ready=1 → req_ready=5'b00010 the same cycle; next cycle wb_valid=1, wb_rd=7, wb_data=0x1234, wb_src=3'b001, wb_we=1.
- All five valid continuously, wb_ready=1 → grants in order 0,1,2,3,4,0; one wb_valid per cycle with matching wb_src.
- Backpressure: wb_valid=1, wb_ready=0, req_valid=5'b00100 → req_ready=0, busy_stall=1, outputs hold. Raise wb_ready → source 2 granted that cycle; next cycle wb_src=3'b010.
- rd=0 from CSR source with data 0xFFFF → wb_valid=1, wb_src=3'b011, wb_we=0.
- Wrap-around: rr_ptr=4, req_valid=5'b10001 → source 4 granted and rr_ptr becomes 0; next cycle source 0 granted.
